// File: rtl/level_pkg.sv
// Shared types, widths and default level constants for the per-level gameplay tracker.
// Consumed by level_progress and frame_countdown via import level_pkg::*.
package level_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        PLAY    = 3'd2,
        DONE    = 3'd3,
        TIMEOUT = 3'd4
    } lvl_state_t;

    localparam int SCORE_W = 8;
    localparam int FRAME_W = 16;

    localparam int EASY_TARGET_HITS       = 8;
    localparam int EASY_TIME_FRAMES       = 1800;
    localparam int MEDIUM_TARGET_HITS     = 12;
    localparam int MEDIUM_TIME_FRAMES     = 1200;
    localparam int DEFAULT_PENALTY_FRAMES = 60;

    // Score increment that sticks at all-ones instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        if (v == {SCORE_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(SCORE_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Remaining-hits decrement that floors at zero.
    function automatic logic [SCORE_W-1:0] floor_dec(input logic [SCORE_W-1:0] v);
        if (v == {SCORE_W{1'b0}}) begin
            return v;
        end else begin
            return v - {{(SCORE_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/frame_countdown.sv
// Loadable FRAME_W down-counter stepped by frame ticks; holds at zero and
// publishes a registered zero flag alongside the count.
module frame_countdown
    import level_pkg::*;
#(
    parameter logic [FRAME_W-1:0] RST_VAL = {FRAME_W{1'b0}}
) (
    input  logic               Clk,
    input  logic               reset,
    input  logic               load,
    input  logic [FRAME_W-1:0] load_val,
    input  logic               tick,
    output logic [FRAME_W-1:0] count,
    output logic               zero
);

    logic [FRAME_W-1:0] count_r;
    logic [FRAME_W-1:0] count_next_s;
    logic               zero_r;

    // Next count: load has priority over a tick; a tick at zero is swallowed.
    always_comb begin
        count_next_s = count_r;
        if (load) begin
            count_next_s = load_val;
        end else if (tick && (count_r != {FRAME_W{1'b0}})) begin
            count_next_s = count_r - {{(FRAME_W-1){1'b0}}, 1'b1};
        end else begin
            count_next_s = count_r;
        end
    end

    // Count and zero flag registered together so they never disagree.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            count_r <= RST_VAL;
            zero_r  <= (RST_VAL == {FRAME_W{1'b0}});
        end else begin
            count_r <= count_next_s;
            zero_r  <= (count_next_s == {FRAME_W{1'b0}});
        end
    end

    assign count = count_r;
    assign zero  = zero_r;

endmodule

// File: rtl/level_progress.sv
// Per-level gameplay tracker: counts hits toward a target and reports score/progress.
// Optional build macro LEVEL_TIMER_EN adds the frame countdown, TIMEOUT state and retry.
module level_progress
    import level_pkg::*;
#(
    parameter int TARGET_HITS    = EASY_TARGET_HITS,
    parameter int TIME_FRAMES    = EASY_TIME_FRAMES,
    parameter int PENALTY_FRAMES = DEFAULT_PENALTY_FRAMES
) (
    input  logic               Clk,
    input  logic               reset,
    input  logic               level_start,
    input  logic               frame_tick,
    input  logic               hit,
    output logic               level_done,
    output logic               timed_out,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] hits_left,
    output logic [FRAME_W-1:0] frames_left
);

    localparam logic [SCORE_W-1:0] TARGET_LOAD = SCORE_W'(TARGET_HITS);

    lvl_state_t         state_r;
    logic               level_done_r;
    logic [SCORE_W-1:0] score_r;
    logic [SCORE_W-1:0] hits_left_r;
    logic               abort_s;
    logic               target_met_s;

    assign abort_s      = (state_r != IDLE) && !level_start;
    assign target_met_s = (hits_left_r == {SCORE_W{1'b0}});

`ifdef LEVEL_TIMER_EN
    localparam logic [FRAME_W-1:0] FRAME_LOAD   = FRAME_W'(TIME_FRAMES);
    localparam logic [FRAME_W-1:0] PENALTY_LOAD = FRAME_W'(PENALTY_FRAMES);

    logic               timed_out_r;
    logic               frame_load_s;
    logic               frame_dec_s;
    logic               frame_zero_s;
    logic               pen_load_s;
    logic               pen_dec_s;
    logic               pen_zero_s;
    logic [FRAME_W-1:0] frames_left_s;
    logic [FRAME_W-1:0] penalty_count_unused_s;

    // Timer strobes; once the target is met the attempt timer is frozen so DONE beats TIMEOUT.
    always_comb begin
        frame_load_s = abort_s || (state_r == ARM);
        frame_dec_s  = (state_r == PLAY) && !abort_s && !target_met_s
                       && !frame_zero_s && frame_tick;
        pen_load_s   = (state_r == PLAY) && !abort_s && !target_met_s && frame_zero_s;
        pen_dec_s    = (state_r == TIMEOUT) && !abort_s && frame_tick;
    end

    frame_countdown #(
        .RST_VAL (FRAME_LOAD)
    ) u_attempt_timer (
        .Clk      (Clk),
        .reset    (reset),
        .load     (frame_load_s),
        .load_val (FRAME_LOAD),
        .tick     (frame_dec_s),
        .count    (frames_left_s),
        .zero     (frame_zero_s)
    );

    frame_countdown #(
        .RST_VAL ({FRAME_W{1'b0}})
    ) u_penalty_timer (
        .Clk      (Clk),
        .reset    (reset),
        .load     (pen_load_s),
        .load_val (PENALTY_LOAD),
        .tick     (pen_dec_s),
        .count    (penalty_count_unused_s),
        .zero     (pen_zero_s)
    );

    assign frames_left = frames_left_s;
    assign timed_out   = timed_out_r;
`else
    logic unused_s;

    assign unused_s    = frame_tick ^ TIME_FRAMES[0] ^ PENALTY_FRAMES[0];
    assign frames_left = {FRAME_W{1'b0}};
    assign timed_out   = 1'b0;
`endif

    // Level FSM with registered outputs; an abort returns everything but score to reset values.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            level_done_r <= 1'b0;
            score_r      <= {SCORE_W{1'b0}};
            hits_left_r  <= TARGET_LOAD;
`ifdef LEVEL_TIMER_EN
            timed_out_r  <= 1'b0;
`endif
        end else if (abort_s) begin
            state_r      <= IDLE;
            level_done_r <= 1'b0;
            hits_left_r  <= TARGET_LOAD;
`ifdef LEVEL_TIMER_EN
            timed_out_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (level_start) begin
                        state_r <= ARM;
                    end
                end
                ARM: begin
                    state_r     <= PLAY;
                    score_r     <= {SCORE_W{1'b0}};
                    hits_left_r <= TARGET_LOAD;
                end
                PLAY: begin
                    if (target_met_s) begin
                        state_r      <= DONE;
                        level_done_r <= 1'b1;
`ifdef LEVEL_TIMER_EN
                    end else if (frame_zero_s) begin
                        state_r     <= TIMEOUT;
                        timed_out_r <= 1'b1;
`endif
                    end else if (hit) begin
                        score_r     <= sat_inc(score_r);
                        hits_left_r <= floor_dec(hits_left_r);
                    end
                end
                DONE: begin
                    state_r <= DONE;
                end
`ifdef LEVEL_TIMER_EN
                TIMEOUT: begin
                    if (pen_zero_s) begin
                        state_r     <= ARM;
                        timed_out_r <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_r      <= IDLE;
                    level_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign level_done = level_done_r;
    assign score      = score_r;
    assign hits_left  = hits_left_r;

endmodule
